bcd_serial_adder: RTL and testbench

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

---
 rtl/bcd_serial_adder_if.sv | 30 +++
 rtl/bcd_serial_adder.sv | 154 +++++++++++++++
 tb/tb_bcd_serial_adder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_adder_if.sv
// Handshake and data bundle for bcd_serial_adder.
// Macro BCD_INVALID_CHECK_EN (in the adder) controls what drives err.
// Signals: start/a/b/cin (request side), ready/busy/done/sum/cout/err (result side).
interface bcd_serial_adder_if #(
   parameter int unsigned NDIG = 4
);
   localparam int unsigned W = 4 * NDIG;

   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          ready;
   logic          busy;
   logic          done;
   logic [W-1:0]  sum;
   logic          cout;
   logic          err;

   // Requester drives the operands and start; the adder drives status and result.
   modport master (
      output start, a, b, cin,
      input  ready, busy, done, sum, cout, err
   );

   modport slave (
      input  start, a, b, cin,
      output ready, busy, done, sum, cout, err
   );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, NDIG digits per operand.
// Ports: clk, rst_n (synchronous, active-low), bus (bcd_serial_adder_if.slave):
//   start/a/b/cin in; ready/busy/done/sum/cout/err out (all registered).
// Optional macro BCD_INVALID_CHECK_EN: flags operands holding a non-decimal digit
//   through err; without it err is tied low.
module bcd_serial_adder #(
   parameter int unsigned NDIG = 4
) (
   input logic               clk,
   input logic               rst_n,
   bcd_serial_adder_if.slave bus
);
   localparam int unsigned W  = 4 * NDIG;
   localparam int unsigned KW = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADD  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [1:0]    next_state;
   logic [KW-1:0] k;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic          c;
   logic [W-1:0]  shadow;
   logic [W-1:0]  sum_q;
   logic          cout_q;
   logic          ready_q;
   logic          busy_q;
   logic          done_q;

   logic          last_c;
   logic [4:0]    t_c;
   logic [3:0]    digit_c;
   logic          c_next_c;
   logic [W-1:0]  shadow_next_c;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = ADD;
         ADD:     if (last_c)    next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Status flags registered from the upcoming state so they line up with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         ready_q <= (next_state == IDLE);
         busy_q  <= (next_state != IDLE);
         done_q  <= (next_state == DONE);
      end
   end

   // One decimal digit: operands are shifted right so the active digit sits at [3:0].
   always_comb begin
      last_c   = (k == KW'(NDIG - 1));
      t_c      = 5'(a_sh[3:0]) + 5'(b_sh[3:0]) + 5'(c);
      digit_c  = t_c[3:0];
      c_next_c = 1'b0;
      if (t_c > 5'd9) begin
         digit_c  = 4'(t_c - 5'd10);
         c_next_c = 1'b1;
      end
      // New digit enters at the top; after NDIG steps digit 0 lands in [3:0].
      shadow_next_c = (shadow >> 4) | (W'(digit_c) << (W - 4));
   end

`ifdef BCD_INVALID_CHECK_EN
   logic inv_c;
   logic inv_q;
   logic err_q;

   // Any digit of either operand above 9.
   always_comb begin
      inv_c = 1'b0;
      for (int i = 0; i < int'(NDIG); i++) begin
         if ((bus.a[4*i +: 4] > 4'd9) || (bus.b[4*i +: 4] > 4'd9)) inv_c = 1'b1;
      end
   end
`endif

   // Operand capture, digit iteration and result publication.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k      <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         c      <= 1'b0;
         shadow <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
         inv_q  <= 1'b0;
         err_q  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh <= bus.a;
                  b_sh <= bus.b;
                  c    <= bus.cin;
                  k    <= '0;
`ifdef BCD_INVALID_CHECK_EN
                  inv_q <= inv_c;
`endif
               end
            end
            ADD: begin
               a_sh   <= a_sh >> 4;
               b_sh   <= b_sh >> 4;
               c      <= c_next_c;
               shadow <= shadow_next_c;
               k      <= k + KW'(1);
               // Publish on the final digit so sum is already valid while done is high.
               if (last_c) begin
                  sum_q  <= shadow_next_c;
                  cout_q <= c_next_c;
`ifdef BCD_INVALID_CHECK_EN
                  err_q  <= inv_q;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.sum   = sum_q;
   assign bus.cout  = cout_q;
`ifdef BCD_INVALID_CHECK_EN
   assign bus.err   = err_q;
`else
   assign bus.err   = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (NDIG=4), scoreboard-based.
module tb_bcd_serial_adder;
   localparam int unsigned NDIG = 4;
   localparam int unsigned W    = 4 * NDIG;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         err;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   exp_t sb[$];

   bcd_serial_adder_if #(.NDIG(NDIG)) bus ();

   bcd_serial_adder #(.NDIG(NDIG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference digit-by-digit decimal addition.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic invalid);
      exp_t r;
      int   cc;
      int   t;
      logic [3:0] da;
      logic [3:0] db;
      cc = int'(cin);
      r.sum = '0;
      for (int i = 0; i < int'(NDIG); i++) begin
         da = a[4*i +: 4];
         db = b[4*i +: 4];
         t  = int'(da) + int'(db) + cc;
         if (t > 9) begin
            r.sum[4*i +: 4] = 4'((t - 10) % 16);
            cc = 1;
         end else begin
            r.sum[4*i +: 4] = 4'(t);
            cc = 0;
         end
      end
      r.cout = (cc != 0);
`ifdef BCD_INVALID_CHECK_EN
      r.err = invalid;
`else
      r.err = 1'b0;
`endif
      return r;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v;
      for (int i = 0; i < int'(NDIG); i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   // Present a request for one cycle; returns in cycle 1 (#1 after the accepting edge).
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Cycle number (relative to acceptance) at which done is seen; -1 on timeout.
   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int n = 1; n < 40; n++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            cyc = n;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
      total++; if ({bus.sum, bus.cout, bus.err} !== {16'h0000, 1'b0, 1'b0}) begin
         bad++; $display("FAIL reset_result got=%h/%b/%b want=0000/0/0", bus.sum, bus.cout, bus.err);
      end
   endtask

   task automatic test_basic();
      int           cyc;
      exp_t         e;
      exp_t         got;
      logic [W-1:0] prev;
      prev = bus.sum;
      sb.push_back(model(16'h1234, 16'h5678, 1'b0, 1'b0));
      issue(16'h1234, 16'h5678, 1'b0);
      cyc = -1;
      for (int n = 1; n < 40; n++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin cyc = n; break; end
         // Result must not show partial values while adding.
         total++; if (bus.sum !== prev) begin bad++; $display("FAIL basic_hold cyc=%0d got=%h want=%h", n, bus.sum, prev); end
         total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy cyc=%0d got=%b want=1", n, bus.busy); end
         @(posedge clk); #1;
      end
      total++; if (cyc != 5) begin bad++; $display("FAIL basic_latency got=%0d want=5", cyc); end
      e = sb.pop_front();
      got = '{sum: bus.sum, cout: bus.cout, err: bus.err};
      total++; if (got !== e) begin bad++; $display("FAIL basic_result got=%h/%b/%b want=%h/%b/%b", got.sum, got.cout, got.err, e.sum, e.cout, e.err); end
      total++; if (bus.sum !== 16'h6912) begin bad++; $display("FAIL basic_const got=%h want=6912", bus.sum); end
      total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL basic_ready_at_done got=%b want=0", bus.ready); end
      @(posedge clk); @(negedge clk);
      total++; if ({bus.ready, bus.done, bus.busy} !== 3'b100) begin
         bad++; $display("FAIL basic_after_done got=%b want=100", {bus.ready, bus.done, bus.busy});
      end
      total++; if (bus.sum !== 16'h6912) begin bad++; $display("FAIL basic_sum_held got=%h want=6912", bus.sum); end
   endtask

   task automatic test_carry();
      logic [W-1:0] av[10];
      logic [W-1:0] bv[10];
      logic         cv[10];
      int           cyc;
      exp_t         e;
      av[0] = 16'h9999; bv[0] = 16'h0001; cv[0] = 1'b0;
      av[1] = 16'h9999; bv[1] = 16'h9999; cv[1] = 1'b1;
      for (int i = 2; i < 10; i++) begin
         av[i] = rand_bcd(); bv[i] = rand_bcd(); cv[i] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 10; i++) begin
         sb.push_back(model(av[i], bv[i], cv[i], 1'b0));
         issue(av[i], bv[i], cv[i]);
         wait_done(cyc);
         total++;
         if (cyc != 5) begin
            bad++; $display("FAIL carry_latency op=%0d got=%0d want=5", i, cyc);
            void'(sb.pop_front());
         end else begin
            e = sb.pop_front();
            if ({bus.sum, bus.cout, bus.err} !== {e.sum, e.cout, e.err}) begin
               bad++; $display("FAIL carry_result op=%0d a=%h b=%h cin=%b got=%h/%b want=%h/%b",
                               i, av[i], bv[i], cv[i], bus.sum, bus.cout, e.sum, e.cout);
            end
         end
      end
      // Spot-check the fixed vectors against literal answers as well.
      sb.push_back('{sum: 16'h9999, cout: 1'b1, err: 1'b0});
      issue(16'h9999, 16'h9999, 1'b1);
      wait_done(cyc);
      e = sb.pop_front();
      total++; if (cyc != 5 || {bus.sum, bus.cout} !== {e.sum, e.cout}) begin
         bad++; $display("FAIL carry_9999 cyc=%0d got=%h/%b want=%h/%b", cyc, bus.sum, bus.cout, e.sum, e.cout);
      end
   endtask

   task automatic test_ignore_start();
      int   ndone;
      int   dcyc;
      exp_t e;
      sb.push_back(model(16'h0450, 16'h0550, 1'b1, 1'b0));
      issue(16'h0450, 16'h0550, 1'b1);
      ndone = 0; dcyc = -1;
      for (int n = 1; n <= 12; n++) begin
         if (n == 2) begin
            bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         if (n <= 5) begin
            total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ignore_busy cyc=%0d got=%b want=1", n, bus.busy); end
         end
         if (bus.done === 1'b1) begin
            ndone++;
            if (dcyc < 0) dcyc = n;
         end
         @(posedge clk); #1;
      end
      total++; if (ndone != 1 || dcyc != 5) begin bad++; $display("FAIL ignore_done count=%0d cyc=%0d want=1@5", ndone, dcyc); end
      e = sb.pop_front();
      total++; if ({bus.sum, bus.cout} !== {e.sum, e.cout}) begin
         bad++; $display("FAIL ignore_result got=%h/%b want=%h/%b", bus.sum, bus.cout, e.sum, e.cout);
      end
   endtask

   task automatic test_reset_mid();
      int   ndone;
      int   cyc;
      exp_t e;
      issue(16'h3333, 16'h4444, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      total++; if ({bus.ready, bus.busy, bus.sum, bus.cout} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
         bad++; $display("FAIL abort_state got=%b/%b/%h/%b want=1/0/0000/0", bus.ready, bus.busy, bus.sum, bus.cout);
      end
      ndone = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      total++; if (ndone != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", ndone); end
      sb.push_back(model(16'h0808, 16'h0202, 1'b0, 1'b0));
      issue(16'h0808, 16'h0202, 1'b0);
      wait_done(cyc);
      e = sb.pop_front();
      total++; if (cyc != 5 || bus.sum !== e.sum || bus.cout !== e.cout) begin
         bad++; $display("FAIL abort_recover cyc=%0d got=%h/%b want=%h/%b", cyc, bus.sum, bus.cout, e.sum, e.cout);
      end
   endtask

   task automatic test_invalid();
      int   cyc;
      exp_t e;
      sb.push_back(model(16'h00A0, 16'h0000, 1'b0, 1'b1));
      issue(16'h00A0, 16'h0000, 1'b0);
      wait_done(cyc);
      e = sb.pop_front();
      total++; if (cyc != 5 || {bus.sum, bus.cout, bus.err} !== {16'h0100, 1'b0, e.err}) begin
         bad++; $display("FAIL invalid_digit cyc=%0d got=%h/%b/%b want=0100/0/%b", cyc, bus.sum, bus.cout, bus.err, e.err);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] av[3];
      logic [W-1:0] bv[3];
      int   idx;
      int   ndone;
      int   last;
      bit   acc;
      exp_t e;
      av[0] = 16'h0123; bv[0] = 16'h0987;
      av[1] = 16'h5000; bv[1] = 16'h5000;
      av[2] = 16'h2468; bv[2] = 16'h1357;
      @(posedge clk); #1;
      idx = 0; ndone = 0; last = -1;
      bus.start = 1'b1; bus.a = av[0]; bus.b = bv[0]; bus.cin = 1'b0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         acc = 1'b0;
         @(negedge clk);
         if (bus.ready === 1'b1 && bus.start === 1'b1 && idx < 3) begin
            sb.push_back(model(av[idx], bv[idx], 1'b0, 1'b0));
            acc = 1'b1;
         end
         if (bus.done === 1'b1) begin
            ndone++;
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL b2b_extra_done cyc=%0d", cyc);
            end else begin
               e = sb.pop_front();
               if ({bus.sum, bus.cout} !== {e.sum, e.cout}) begin
                  bad++; $display("FAIL b2b_result cyc=%0d got=%h/%b want=%h/%b", cyc, bus.sum, bus.cout, e.sum, e.cout);
               end
            end
            if (last >= 0) begin
               total++; if (cyc - last != int'(NDIG) + 2) begin bad++; $display("FAIL b2b_period got=%0d want=%0d", cyc - last, NDIG + 2); end
            end
            last = cyc;
         end
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 3) begin bus.a = av[idx]; bus.b = bv[idx]; end
            else bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      total++; if (ndone != 3 || sb.size() != 0) begin
         bad++; $display("FAIL b2b_count got=%0d pending=%0d want=3/0", ndone, sb.size());
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      test_reset();
      test_basic();
      test_carry();
      test_ignore_start();
      test_reset_mid();
      test_invalid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
